// File: rtl/ticket_pkg.sv
// Shared encodings for the ticket machine's change path: FSM states,
// coin denominations in hopper bit order [50,20,10,5,1], and datapath widths.
package ticket_pkg;

    localparam int AMT_W   = 7;
    localparam int DENOM_N = 5;

    localparam int IDX_50 = 4;
    localparam int IDX_20 = 3;
    localparam int IDX_10 = 2;
    localparam int IDX_5  = 1;
    localparam int IDX_1  = 0;

    localparam logic [AMT_W-1:0] DENOM_50 = 7'd50;
    localparam logic [AMT_W-1:0] DENOM_20 = 7'd20;
    localparam logic [AMT_W-1:0] DENOM_10 = 7'd10;
    localparam logic [AMT_W-1:0] DENOM_5  = 7'd5;
    localparam logic [AMT_W-1:0] DENOM_1  = 7'd1;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_SELECT   = 5'b00010,
        ST_WAIT_ACK = 5'b00100,
        ST_DONE     = 5'b01000,
        ST_FAULT    = 5'b10000
    } state_t;

    // Value of a one-hot coin selection; an all-zero selection is worth 0.
    function automatic logic [AMT_W-1:0] denom_value(input logic [DENOM_N-1:0] sel);
        return ({AMT_W{sel[IDX_50]}} & DENOM_50) |
               ({AMT_W{sel[IDX_20]}} & DENOM_20) |
               ({AMT_W{sel[IDX_10]}} & DENOM_10) |
               ({AMT_W{sel[IDX_5]}}  & DENOM_5)  |
               ({AMT_W{sel[IDX_1]}}  & DENOM_1);
    endfunction

endpackage

// File: rtl/coin_selector.sv
// Greedy coin picker: largest denomination that fits in the amount owed and
// whose tube still holds coins. Purely combinational.
module coin_selector
    import ticket_pkg::*;
(
    input  logic [AMT_W-1:0]   owed,
    input  logic [DENOM_N-1:0] hopper_empty,
    output logic [DENOM_N-1:0] coin_sel,
    output logic               none_eligible
);

    always_comb begin
        coin_sel = '0;
        if (!hopper_empty[IDX_50] && owed >= DENOM_50) begin
            coin_sel[IDX_50] = 1'b1;
        end else if (!hopper_empty[IDX_20] && owed >= DENOM_20) begin
            coin_sel[IDX_20] = 1'b1;
        end else if (!hopper_empty[IDX_10] && owed >= DENOM_10) begin
            coin_sel[IDX_10] = 1'b1;
        end else if (!hopper_empty[IDX_5] && owed >= DENOM_5) begin
            coin_sel[IDX_5] = 1'b1;
        end else if (!hopper_empty[IDX_1] && owed >= DENOM_1) begin
            coin_sel[IDX_1] = 1'b1;
        end
        none_eligible = (coin_sel == '0);
    end

endmodule

// File: rtl/change_dispenser.sv
// Dispenses change one coin at a time through the hopper, tracking what is
// still owed and raising a fault on an unpayable remainder or a silent hopper.
module change_dispenser
    import ticket_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               disp_valid,
    input  logic [AMT_W-1:0]   disp_amt,
    input  logic [DENOM_N-1:0] hopper_empty,
    input  logic               coin_ack,
    input  logic               fault_clr,
    output logic               disp_ready,
    output logic               coin_req,
    output logic [DENOM_N-1:0] coin_sel,
    output logic [AMT_W-1:0]   owed,
    output logic [CNT_W-1:0]   coin_count,
    output logic               done,
    output logic               fault,
    output logic [4:0]         state
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    state_t             state_q;
    logic [TMR_W-1:0]   ack_timer;
    logic [DENOM_N-1:0] pick;
    logic               none_eligible;

    coin_selector u_coin_selector (
        .owed          (owed),
        .hopper_empty  (hopper_empty),
        .coin_sel      (pick),
        .none_eligible (none_eligible)
    );

    assign state = state_q;

    // Every output is set on the transition into the state that owns it,
    // so all outputs come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            disp_ready <= 1'b1;
            coin_req   <= 1'b0;
            coin_sel   <= '0;
            owed       <= '0;
            coin_count <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
            ack_timer  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (disp_valid) begin
                        owed       <= disp_amt;
                        coin_count <= '0;
                        disp_ready <= 1'b0;
                        if (disp_amt == '0) begin
                            done    <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_SELECT;
                        end
                    end
                end
                ST_SELECT: begin
                    if (owed == '0) begin
                        coin_sel <= '0;
                        done     <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (none_eligible) begin
                        coin_sel <= '0;
                        fault    <= 1'b1;
                        state_q  <= ST_FAULT;
                    end else begin
                        coin_sel <= pick;
                        coin_req <= 1'b1;
                        state_q  <= ST_WAIT_ACK;
                    end
                end
                // An ack arriving on the timeout cycle still counts as a coin.
                ST_WAIT_ACK: begin
                    if (coin_ack) begin
                        owed       <= owed - denom_value(coin_sel);
                        coin_count <= coin_count + 1'b1;
                        ack_timer  <= '0;
                        coin_req   <= 1'b0;
                        state_q    <= ST_SELECT;
                    end else if (ack_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                        ack_timer <= ack_timer + 1'b1;
                        coin_req  <= 1'b0;
                        fault     <= 1'b1;
                        state_q   <= ST_FAULT;
                    end else begin
                        ack_timer <= ack_timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    disp_ready <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        owed       <= '0;
                        fault      <= 1'b0;
                        ack_timer  <= '0;
                        disp_ready <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    coin_req   <= 1'b0;
                    fault      <= 1'b0;
                    disp_ready <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: directed loads push expected coin,
// done and fault events; a monitor pops and compares them as the DUT emits them.
module tb_change_dispenser;

    localparam int EV_COIN  = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_FAULT = 2;

    typedef struct {
        int         kind;
        logic [4:0] sel;
        int         count;
        int         owed;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       disp_valid = 1'b0;
    logic [6:0] disp_amt = '0;
    logic [4:0] hopper_empty = '0;
    logic       coin_ack = 1'b0;
    logic       fault_clr = 1'b0;
    logic       disp_ready;
    logic       coin_req;
    logic [4:0] coin_sel;
    logic [6:0] owed;
    logic [2:0] coin_count;
    logic       done;
    logic       fault;
    logic [4:0] state;

    int   total = 0;
    int   bad = 0;
    bit   ack_en = 1'b0;
    int   ack_wait = 0;
    exp_t sb[$];

    change_dispenser #(.ACK_TIMEOUT(15), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .disp_valid   (disp_valid),
        .disp_amt     (disp_amt),
        .hopper_empty (hopper_empty),
        .coin_ack     (coin_ack),
        .fault_clr    (fault_clr),
        .disp_ready   (disp_ready),
        .coin_req     (coin_req),
        .coin_sel     (coin_sel),
        .owed         (owed),
        .coin_count   (coin_count),
        .done         (done),
        .fault        (fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int kind, input logic [4:0] sel, input int count, input int amt);
        exp_t e;
        e.kind = kind;
        e.sel = sel;
        e.count = count;
        e.owed = amt;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [6:0] amt, input logic [4:0] empty);
        @(negedge clk);
        hopper_empty = empty;
        disp_amt = amt;
        disp_valid = 1'b1;
        @(negedge clk);
        disp_valid = 1'b0;
    endtask

    task automatic waitSettle(input int bound);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (state == 5'b00001 || state == 5'b10000) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("settle_timeout", 32'(hit), 32'd1);
    endtask

    // Hopper model: acks two cycles after each request while enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (coin_ack) begin
                coin_ack = 1'b0;
            end else if (coin_req && ack_en) begin
                ack_wait++;
                if (ack_wait >= 2) begin
                    coin_ack = 1'b1;
                    ack_wait = 0;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    // Monitor: each coin request, done pulse and fault entry consumes one expectation.
    initial begin
        logic prev_req;
        logic prev_fault;
        exp_t e;
        prev_req = 1'b0;
        prev_fault = 1'b0;
        forever begin
            @(negedge clk);
            if (coin_req && !prev_req) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL unexpected_coin: got sel %b, expected no event", coin_sel);
                end else begin
                    e = sb.pop_front();
                    checkOutput("coin_event_kind", EV_COIN, e.kind);
                    checkOutput("coin_sel", 32'(coin_sel), 32'(e.sel));
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no event");
                end else begin
                    e = sb.pop_front();
                    checkOutput("done_event_kind", EV_DONE, e.kind);
                    checkOutput("done_coin_count", 32'(coin_count), 32'(e.count));
                    checkOutput("done_owed", 32'(owed), 32'(e.owed));
                    checkOutput("done_coin_req", 32'(coin_req), 32'd0);
                end
            end
            if (fault && !prev_fault) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL unexpected_fault: got fault=1, expected no event");
                end else begin
                    e = sb.pop_front();
                    checkOutput("fault_event_kind", EV_FAULT, e.kind);
                    checkOutput("fault_owed", 32'(owed), 32'(e.owed));
                    checkOutput("fault_coin_count", 32'(coin_count), 32'(e.count));
                end
            end
            prev_req = coin_req;
            prev_fault = fault;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int req_cycles;

        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_state", 32'(state), 32'b00001);
        checkOutput("rst_disp_ready", 32'(disp_ready), 32'd1);
        checkOutput("rst_coin_req", 32'(coin_req), 32'd0);
        checkOutput("rst_coin_sel", 32'(coin_sel), 32'd0);
        checkOutput("rst_owed", 32'(owed), 32'd0);
        checkOutput("rst_coin_count", 32'(coin_count), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;

        $display("[TB] 85 with all tubes full");
        ack_en = 1'b1;
        pushExp(EV_COIN, 5'b10000, 0, 0);
        pushExp(EV_COIN, 5'b01000, 0, 0);
        pushExp(EV_COIN, 5'b00100, 0, 0);
        pushExp(EV_COIN, 5'b00010, 0, 0);
        pushExp(EV_DONE, 5'b00000, 4, 0);
        applyStimulus(7'd85, 5'b00000);
        waitSettle(200);
        checkOutput("t85_state", 32'(state), 32'b00001);

        $display("[TB] 127 with all tubes full");
        pushExp(EV_COIN, 5'b10000, 0, 0);
        pushExp(EV_COIN, 5'b10000, 0, 0);
        pushExp(EV_COIN, 5'b01000, 0, 0);
        pushExp(EV_COIN, 5'b00010, 0, 0);
        pushExp(EV_COIN, 5'b00001, 0, 0);
        pushExp(EV_COIN, 5'b00001, 0, 0);
        pushExp(EV_DONE, 5'b00000, 6, 0);
        applyStimulus(7'd127, 5'b00000);
        waitSettle(200);
        checkOutput("t127_count_hold", 32'(coin_count), 32'd6);

        $display("[TB] 30 with the 20 tube empty");
        pushExp(EV_COIN, 5'b00100, 0, 0);
        pushExp(EV_COIN, 5'b00100, 0, 0);
        pushExp(EV_COIN, 5'b00100, 0, 0);
        pushExp(EV_DONE, 5'b00000, 3, 0);
        applyStimulus(7'd30, 5'b01000);
        waitSettle(200);
        checkOutput("t30_state", 32'(state), 32'b00001);

        $display("[TB] 3 with the 1 tube empty");
        pushExp(EV_FAULT, 5'b00000, 0, 3);
        applyStimulus(7'd3, 5'b00001);
        waitSettle(50);
        checkOutput("t3_state", 32'(state), 32'b10000);
        checkOutput("t3_fault", 32'(fault), 32'd1);
        checkOutput("t3_coin_req", 32'(coin_req), 32'd0);
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checkOutput("t3_clr_state", 32'(state), 32'b00001);
        checkOutput("t3_clr_owed", 32'(owed), 32'd0);
        checkOutput("t3_clr_fault", 32'(fault), 32'd0);

        $display("[TB] 40 with a silent hopper");
        ack_en = 1'b0;
        pushExp(EV_COIN, 5'b01000, 0, 0);
        pushExp(EV_FAULT, 5'b00000, 0, 40);
        applyStimulus(7'd40, 5'b00000);
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fault) break;
            if (coin_req) req_cycles++;
        end
        checkOutput("t40_req_cycles", 32'(req_cycles), 32'd15);
        checkOutput("t40_state", 32'(state), 32'b10000);
        checkOutput("t40_owed", 32'(owed), 32'd40);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checkOutput("t40_clr_state", 32'(state), 32'b00001);

        $display("[TB] zero amount");
        pushExp(EV_DONE, 5'b00000, 0, 0);
        applyStimulus(7'd0, 5'b00000);
        checkOutput("t0_done_next_cycle", 32'(done), 32'd1);
        checkOutput("t0_coin_req", 32'(coin_req), 32'd0);
        waitSettle(20);
        checkOutput("t0_coin_req_after", 32'(coin_req), 32'd0);

        $display("[TB] 60 with reset during WAIT_ACK");
        pushExp(EV_COIN, 5'b10000, 0, 0);
        applyStimulus(7'd60, 5'b00000);
        @(negedge clk);
        checkOutput("t60_wait_state", 32'(state), 32'b00100);
        disp_amt = 7'd5;
        disp_valid = 1'b1;
        @(negedge clk);
        disp_valid = 1'b0;
        checkOutput("t60_ignored_valid_owed", 32'(owed), 32'd60);
        checkOutput("t60_ignored_valid_state", 32'(state), 32'b00100);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t60_async_coin_req", 32'(coin_req), 32'd0);
        checkOutput("t60_async_state", 32'(state), 32'b00001);
        checkOutput("t60_async_owed", 32'(owed), 32'd0);
        checkOutput("t60_async_ready", 32'(disp_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("scoreboard_leftover", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
